// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - ALU control op codes consumed by the unit (MULT, DIV, MFHI, MFLO)
//   - OP_SIZE: width of the Operation code
//   - FSM state and datapath mode enumerations
//   - is_md_op(): true for any op code this unit owns
package mult_div_unit_pkg;

  localparam int unsigned OP_SIZE = 6;

  localparam logic [OP_SIZE-1:0] ALU_DIV  = 6'b001011;
  localparam logic [OP_SIZE-1:0] ALU_MULT = 6'b001100;
  localparam logic [OP_SIZE-1:0] ALU_MFHI = 6'b001101;
  localparam logic [OP_SIZE-1:0] ALU_MFLO = 6'b001110;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_FIX  = 2'd3
  } md_state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } md_mode_e;

  function automatic logic is_md_op(input logic [OP_SIZE-1:0] op);
    return (op == ALU_DIV) || (op == ALU_MULT) || (op == ALU_MFHI) || (op == ALU_MFLO);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Pipeline-side bus of the multiply/divide unit.
//   master (pipeline): drives start, Operation, A, B
//   slave  (unit)    : drives Result, busy, done, stall, div_zero
interface mult_div_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_SIZE    = mult_div_unit_pkg::OP_SIZE
);
  logic                  start;
  logic [OP_SIZE-1:0]    Operation;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [DATA_WIDTH-1:0] Result;
  logic                  busy;
  logic                  done;
  logic                  stall;
  logic                  div_zero;

  modport master (
    output start, Operation, A, B,
    input  Result, busy, done, stall, div_zero
  );

  modport slave (
    input  start, Operation, A, B,
    output Result, busy, done, stall, div_zero
  );
endinterface

// File: rtl/mult_div_unit_shift_core.sv
// md_shift_core: unsigned iterative datapath for the multiply/divide unit.
//   clk, rst_n : clock, async active-low reset
//   load       : capture magnitudes and mode, clear counter, start iterating
//   mode       : MODE_MUL (shift-add) or MODE_DIV (restoring division)
//   a_mag      : multiplier / dividend magnitude
//   b_mag      : multiplicand / divisor magnitude
//   raw_hi     : product high half / remainder
//   raw_lo     : product low half / quotient
//   last       : the current cycle performs the final iteration
module md_shift_core
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  md_mode_e              mode,
  input  logic [DATA_WIDTH-1:0] a_mag,
  input  logic [DATA_WIDTH-1:0] b_mag,
  output logic [DATA_WIDTH-1:0] raw_hi,
  output logic [DATA_WIDTH-1:0] raw_lo,
  output logic                  last
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;
  md_mode_e       mode_q, mode_d;

  logic [W:0]     sum;
  logic [W:0]     rem_shl;
  logic [W:0]     trial;

  assign raw_hi = acc_q[2*W-1:W];
  assign raw_lo = acc_q[W-1:0];
  assign last   = run_q && (cnt_q == CW'(DATA_WIDTH - 1));

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    mode_d = mode_q;
    // Multiply: accumulate into the high half with carry, then shift right.
    sum     = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
    // Divide: partial remainder shifted left by one, then trial subtract.
    rem_shl = acc_q[2*W-1:W-1];
    trial   = rem_shl - {1'b0, opnd_q};

    if (load) begin
      acc_d  = {{W{1'b0}}, a_mag};
      opnd_d = b_mag;
      cnt_d  = '0;
      run_d  = 1'b1;
      mode_d = mode;
    end else if (run_q) begin
      if (mode_q == MODE_MUL) begin
        if (acc_q[0]) acc_d = {sum, acc_q[W-1:1]};
        else          acc_d = {1'b0, acc_q[2*W-1:1]};
      end else begin
        // Non-negative trial keeps the subtraction and records a 1 quotient bit.
        if (!trial[W]) acc_d = {trial[W-1:0], acc_q[W-2:0], 1'b1};
        else           acc_d = {acc_q[2*W-2:0], 1'b0};
      end
      cnt_d = cnt_q + CW'(1);
      if (last) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      mode_q <= MODE_MUL;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      mode_q <= mode_d;
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed MULT/DIV with HI/LO registers.
//   clk, rst_n      : clock, async active-low reset
//   bus.start       : instruction valid
//   bus.Operation   : ALU control op code (MULT, DIV, MFHI, MFLO used)
//   bus.A, bus.B    : rs / rt operands
//   bus.Result      : HI for MFHI, LO for MFLO, else 0
//   bus.busy        : operation in flight
//   bus.done        : one-cycle pulse after HI/LO update
//   bus.stall       : interlock while an owned op meets a busy unit
//   bus.div_zero    : last accepted DIV had a zero divisor (sticky)
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_SIZE    = mult_div_unit_pkg::OP_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_div_unit_if.slave  bus
);
  localparam int unsigned W = DATA_WIDTH;

  logic [OP_SIZE-1:0] op;
  logic               is_mult, is_div, a_neg, b_neg;
  logic [W-1:0]       a_mag, b_mag, raw_hi, raw_lo, result;
  logic               core_load, core_last;
  md_mode_e           core_mode;
  logic [2*W-1:0]     prod_mag, prod_signed;

  md_state_e          state_q, state_d;
  logic [W-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               dz_q, dz_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic               op_div_q, op_div_d;

  assign op          = bus.Operation;
  assign is_mult     = (op == ALU_MULT);
  assign is_div      = (op == ALU_DIV);
  assign a_neg       = bus.A[W-1];
  assign b_neg       = bus.B[W-1];
  assign a_mag       = a_neg ? -bus.A : bus.A;
  assign b_mag       = b_neg ? -bus.B : bus.B;
  assign prod_mag    = {raw_hi, raw_lo};
  assign prod_signed = qneg_q ? -prod_mag : prod_mag;

  md_shift_core #(
    .DATA_WIDTH (W)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (core_load),
    .mode   (core_mode),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .raw_hi (raw_hi),
    .raw_lo (raw_lo),
    .last   (core_last)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    op_div_d  = op_div_q;
    core_load = 1'b0;
    core_mode = MODE_MUL;

    unique case (state_q)
      MD_IDLE: begin
        if (bus.start && (is_mult || is_div)) begin
          core_load = 1'b1;
          core_mode = is_div ? MODE_DIV : MODE_MUL;
          state_d   = is_div ? MD_DIV : MD_MUL;
          op_div_d  = is_div;
          qneg_d    = a_neg ^ b_neg;
          rneg_d    = a_neg;
          dz_d      = is_div && (bus.B == '0);
        end
      end
      MD_MUL, MD_DIV: begin
        if (core_last) state_d = MD_FIX;
      end
      MD_FIX: begin
        // Zero divisor leaves |A| as remainder, so the dividend sign restores A.
        if (op_div_q) begin
          hi_d = rneg_q ? -raw_hi : raw_hi;
          lo_d = dz_q ? '1 : (qneg_q ? -raw_lo : raw_lo);
        end else begin
          {hi_d, lo_d} = prod_signed;
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase

    busy_d = (state_d != MD_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      op_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      op_div_q <= op_div_d;
    end
  end

  always_comb begin
    result = '0;
    if (op == ALU_MFHI)      result = hi_q;
    else if (op == ALU_MFLO) result = lo_q;
  end

  assign bus.Result   = result;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.stall    = bus.start && is_md_op(op) && (state_q != MD_IDLE);
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed multiply/divide unit with HI/LO registers. Sits directly downstream of the ALU control decoder: consumes its `Operation` code for the MULT, DIV, MFHI and MFLO encodings. Those codes are not routed to the combinational ALU; this block executes them instead and returns an interlock to the pipeline while an operation is in flight.

## Interface

Reset is asynchronous and active-low.

Parameters:
- `DATA_WIDTH`, default 32: operand, HI and LO width; the iteration count equals `DATA_WIDTH`.
- `OP_SIZE`, default 6: width of `Operation`; value taken from `parameters.v`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  instruction valid at this stage.
- `Operation`  in  OP_SIZE  op code from ALU control.
- `A`  in  DATA_WIDTH  rs operand: multiplicand or dividend.
- `B`  in  DATA_WIDTH  rt operand: multiplier or divisor.
- `Result`  out  DATA_WIDTH  HI for MFHI, LO for MFLO, 0 otherwise.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse: HI/LO just updated.
- `stall`  out  1  pipeline interlock.
- `div_zero`  out  1  last DIV had a zero divisor; sticky until the next accepted MULT or DIV.

## Operation

- Op codes, all defined in `parameters.v`:
  - `ALU_DIV` = 6'b001011
  - `ALU_MULT` = 6'b001100
  - `ALU_MFHI` = 6'b001101
  - `ALU_MFLO` = 6'b001110
  - Any other code: no effect.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - `start` with MULT goes to MUL; `start` with DIV goes to DIV.
  - On accept: latch operand magnitudes, result sign(s) and the zero-divisor flag; clear iteration counter.
- MUL: shift-add on magnitudes, one multiplier bit per cycle for `DATA_WIDTH` cycles, then go to FIX.
- DIV: restoring division, one quotient bit per cycle for `DATA_WIDTH` cycles, then go to FIX.
- FIX: apply signs, write HI/LO, go to IDLE.
- Arithmetic (signed two's complement):
  - MULT: {HI,LO} = the full 2·DATA_WIDTH-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - Most-negative / −1: LO = 0x80000000, HI = 0 (wraps, no trap).
  - Divisor 0: HI = A, LO = all ones, `div_zero` = 1. The full latency is still taken.
- Result:
  - Combinational mux of the HI/LO registers selected by `Operation`.
  - Independent of `start` and `busy`.
- stall:
  - Asserted when `start` and `Operation` ∈ {MULT, DIV, MFHI, MFLO} and the FSM is not in IDLE.
  - Upstream must hold the instruction while `stall` is high.
- `start` while busy: never accepted; HI/LO and the in-flight operation are unaffected.
- MFHI/MFLO never change state.

## Timing

- Reset values: HI = 0, LO = 0, FSM = IDLE, `busy` = 0, `done` = 0, `stall` = 0, `div_zero` = 0, `Result` = 0.
- Accept edge is T0. `busy` is high from T0+ through T0+DATA_WIDTH+1.
- Iterations occur on edges T1..T32. FIX writes HI/LO on edge T33.
- After T33: `done` = 1 for exactly one cycle, `busy` = 0, FSM = IDLE.
- In the `done` cycle:
  - A new `start` is accepted (back-to-back issue with no gap).
  - MFHI/MFLO return the new values with `stall` = 0.
- Throughput: one MULT/DIV per 34 cycles.
- `rst_n` low at any point, including mid-iteration: all state clears asynchronously. No partial HI/LO write and no `done` pulse.

## Structure

- `parameters.v` (shared) holds:
  - the four op codes above;
  - `OP_SIZE`;
  - the FSM state encodings, named `MD_IDLE`, `MD_MUL`, `MD_DIV` and `MD_FIX`.
- One sub-module, `md_shift_core`, holds the iterative datapath:
  - 2·DATA_WIDTH remainder/product register, shift, conditional add/subtract, counter;
  - inputs: `load`, `mode`, magnitudes;
  - outputs: `raw_hi`, `raw_lo`, `last`.
- The top level holds the FSM, sign handling, HI/LO registers, the `Result` mux and `stall`.

## Test plan

- MULT A=7, B=−3 (0xFFFFFFFD) → after 33 cycles: HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` pulses once, `busy` high exactly 33 cycles.
- MULT A=0x80000000, B=0x80000000 → HI=0x40000000, LO=0; then MFHI returns 0x40000000 with `stall` = 0.
- DIV A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV A=5, B=0 → HI=5, LO=0xFFFFFFFF, `div_zero` = 1. A following MULT 2×3 clears `div_zero`: LO=6, HI=0.
- MFLO presented at T0+5 of a MULT → `stall` = 1 until the `done` cycle. `Result` then equals the new LO. A second MULT issued during `busy` is ignored.
- `rst_n` pulsed low at T0+10 of a DIV → HI=LO=0, `busy` = 0, no `done`. A fresh MULT 3×4 then yields LO=12.
